sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Arbitrates the single-port program/data SRAM between three requesters: the host programming port (loader), the core's load/store unit (data port) and the core's instruction fetch. It sits between the core and the SRAM macro. It owns the host-session state machine that stalls the core while the host writes or reads SRAM, and it routes each one-cycle-latency read return to the requester that issued it.

## Interface
- ADDR_WIDTH, 15, SRAM word-address width (32k words)
- DATA_WIDTH, 32, SRAM word width
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (fairness build only); legal range 1..15

- clk  in  1  core clock
- reset  in  1  synchronous, active-high; one clock; all state clears on the rising edge of clk while reset is high
- h_req  in  1  host request
- h_we  in  1  host write enable
- h_addr  in  ADDR_WIDTH  host address
- h_wdata  in  DATA_WIDTH  host write data
- h_gnt  out  1  host request accepted this cycle
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  data-port request
- d_gnt  out  1  data request accepted this cycle
- f_req, f_addr  in  1/ADDR_WIDTH  fetch read request
- f_gnt  out  1  fetch request accepted this cycle
- rdata  out  DATA_WIDTH  read data, shared by all requesters
- h_rvalid, d_rvalid, f_rvalid  out  1 each  rdata is valid for that requester
- core_hold  out  1  stalls the core while a host session is active
- sram_en, sram_we  out  1 each  SRAM strobes
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after a read strobe

## Operation
- A transfer happens in any cycle where req && gnt. Grants are combinational from the current req and state.
  - sram_en = OR of the grants; sram_we, sram_addr and sram_wdata are muxed from the winner.
  - The loser's req stays high; its address and data must stay stable until it is granted.
- Fetch never writes: sram_we = 0 on a fetch grant.
- FSM states:
  - RUN:
    - h_gnt = 0.
    - Priority is data over fetch, subject to the fairness rule under Configuration.
    - h_req = 1 moves to HOST on the next cycle. Core grants continue in the cycle h_req is first seen.
  - HOST:
    - core_hold = 1; d_gnt = f_gnt = 0; h_gnt = h_req.
    - Exit to RUN after h_req has been low for 2 consecutive cycles. An idle counter clears whenever h_req = 1.
- Read return:
  - A 2-bit owner register captures the winner of each read grant.
  - On the next cycle, exactly that requester's rvalid pulses for 1 cycle, with rdata = sram_rdata.
  - Writes produce no rvalid.
- A read granted in RUN during the cycle before HOST entry still returns its rvalid in the first HOST cycle.
- Reset values: every gnt and rvalid = 0, core_hold = 0, sram_en = 0, sram_we = 0, state = RUN, owner = none, counters = 0.
- Reset mid-transfer: any pending rvalid is dropped and is not re-issued.

## Timing
- Grant latency: 0 cycles (same cycle as req when the requester wins).
- Read latency: grant in cycle N, then rvalid and rdata in cycle N+1. Back-to-back reads give one result per cycle.
- HOST entry: h_req first seen high in cycle N, then core_hold = 1 and the first h_gnt possible in cycle N+1.
- HOST exit: h_req low in cycles M and M+1, then state = RUN and core_hold = 0 in cycle M+2.
- core_hold is registered and changes only on clk edges.

## Configuration
- SRAM_ARB_FAIRNESS_EN defined:
  - A 4-bit starve counter increments each RUN cycle with f_req && !f_gnt, and clears on f_gnt or when f_req = 0.
  - When the counter equals STARVE_LIMIT, fetch wins over data for that cycle.
- SRAM_ARB_FAIRNESS_EN undefined: strict data-over-fetch priority; the counter logic is absent.

## Test plan
- Reset: hold reset 3 cycles with all req high, then release. Required: all outputs 0 during reset; d_gnt = 1 in the first cycle after release.
- Host session: h_req with writes 0x00050693 to address 0 and 0x00000713 to address 1, then read address 1, then h_req low. Required:
  - core_hold rises 1 cycle after h_req.
  - h_rvalid pulses with rdata = 0x00000713.
  - core_hold falls 2 cycles after the last h_req.
- Contention: d_req and f_req both high for 10 cycles. Required:
  - Without the macro: f_gnt stays 0.
  - With the macro and STARVE_LIMIT = 4: f_gnt pulses on cycles 5 and 10.
- Read routing: fetch read of address 14, then data read of address 15 in consecutive cycles. Required: f_rvalid then d_rvalid, each carrying its own word, never both in one cycle.
- Host preemption: h_req rises in the same cycle as a d_req read grant. Required: d_rvalid is still delivered the next cycle, and d_gnt = 0 for the whole session.
- Reset mid-read: assert reset in the cycle after a fetch grant. Required: f_rvalid = 0 and state = RUN.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Request/grant/return bundle between the three SRAM requesters, the arbiter and the SRAM macro.
// slave = arbiter side; master = requesters plus SRAM macro.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  h_req;
    logic                  h_we;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0] h_wdata;
    logic                  h_gnt;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  h_rvalid;
    logic                  d_rvalid;
    logic                  f_rvalid;
    logic                  core_hold;
    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  h_req, h_we, h_addr, h_wdata, d_req, d_we, d_addr, d_wdata,
        input  f_req, f_addr, sram_rdata,
        output h_gnt, d_gnt, f_gnt, rdata, h_rvalid, d_rvalid, f_rvalid,
        output core_hold, sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output h_req, h_we, h_addr, h_wdata, d_req, d_we, d_addr, d_wdata,
        output f_req, f_addr, sram_rdata,
        input  h_gnt, d_gnt, f_gnt, rdata, h_rvalid, d_rvalid, f_rvalid,
        input  core_hold, sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: host session FSM (stalls core), data-over-fetch priority, read-return routing.
// Optional fetch anti-starvation: define SRAM_ARB_FAIRNESS_EN.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                reset,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic {ST_RUN, ST_HOST} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_DATA, OWN_FETCH} owner_e;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic [1:0] idle_q, idle_d;
    logic       core_hold_q, core_hold_d;
    logic       h_gnt, d_gnt, f_gnt;
    logic       fetch_force;

`ifdef SRAM_ARB_FAIRNESS_EN
    logic [3:0] starve_q, starve_d;

    assign fetch_force = (starve_q == 4'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (!bus.f_req || f_gnt) begin
            starve_d = '0;
        end else if (state_q == ST_RUN && starve_q != '1) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    assign fetch_force = 1'b0;
`endif

    // Grants are suppressed while reset is high so nothing reaches the SRAM during reset.
    always_comb begin
        h_gnt = 1'b0;
        d_gnt = 1'b0;
        f_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN: begin
                    d_gnt = bus.d_req && !(fetch_force && bus.f_req);
                    f_gnt = bus.f_req && (!bus.d_req || fetch_force);
                end
                ST_HOST: h_gnt = bus.h_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            ST_RUN: begin
                idle_d = '0;
                if (bus.h_req) state_d = ST_HOST;
            end
            ST_HOST: begin
                if (bus.h_req) begin
                    idle_d = '0;
                end else if (idle_q == 2'd1) begin
                    idle_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    idle_d = idle_q + 2'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        core_hold_d = (state_d == ST_HOST);
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (h_gnt && !bus.h_we)      owner_d = OWN_HOST;
        else if (d_gnt && !bus.d_we) owner_d = OWN_DATA;
        else if (f_gnt)              owner_d = OWN_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            owner_q     <= OWN_NONE;
            idle_q      <= '0;
            core_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            idle_q      <= idle_d;
            core_hold_q <= core_hold_d;
        end
    end

    // Winner mux; fetch is read-only so it never drives we or wdata.
    always_comb begin
        bus.sram_we    = 1'b0;
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        if (h_gnt) begin
            bus.sram_we    = bus.h_we;
            bus.sram_addr  = bus.h_addr;
            bus.sram_wdata = bus.h_wdata;
        end else if (d_gnt) begin
            bus.sram_we    = bus.d_we;
            bus.sram_addr  = bus.d_addr;
            bus.sram_wdata = bus.d_wdata;
        end else if (f_gnt) begin
            bus.sram_addr  = bus.f_addr;
        end
    end

    assign bus.sram_en   = h_gnt | d_gnt | f_gnt;
    assign bus.h_gnt     = h_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.f_gnt     = f_gnt;
    assign bus.core_hold = core_hold_q;
    assign bus.rdata     = bus.sram_rdata;
    assign bus.h_rvalid  = !reset && (owner_q == OWN_HOST);
    assign bus.d_rvalid  = !reset && (owner_q == OWN_DATA);
    assign bus.f_rvalid  = !reset && (owner_q == OWN_FETCH);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: expected read returns are queued at grant time and
// checked by a separate monitor; grants and core_hold are checked inline.
module tb_sram_port_arbiter;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam logic [1:0] WHO_H = 2'd1;
    localparam logic [1:0] WHO_D = 2'd2;
    localparam logic [1:0] WHO_F = 2'd3;
    localparam logic [31:0] W14 = 32'h0000_A00E;
    localparam logic [31:0] W15 = 32'h0000_B00F;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    logic [31:0] mem [0:31];

    sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr[4:0]] <= bus.sram_wdata;
            else             bus.sram_rdata <= mem[bus.sram_addr[4:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] who, input logic [31:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        expq.push_back(e);
    endtask

    // Read-return monitor.
    always @(negedge clk) begin
        logic [1:0] who;
        exp_t e;
        int   n;
        n = int'(bus.h_rvalid) + int'(bus.d_rvalid) + int'(bus.f_rvalid);
        if (n > 1) chk("rvalid_onehot", 32'(n), 32'd1);
        else if (n == 1) begin
            who = bus.h_rvalid ? WHO_H : (bus.d_rvalid ? WHO_D : WHO_F);
            if (expq.size() == 0) begin
                chk("rvalid_unexpected", {30'd0, who}, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("rvalid_owner", {30'd0, who}, {30'd0, e.who});
                chk("rvalid_rdata", bus.rdata, e.data);
            end
        end
    end

    initial begin
        logic exp_f;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[14] = W14;
        mem[15] = W15;
        bus.sram_rdata = '0;

        // Reset with every requester active.
        reset = 1'b1;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 15'd15; bus.d_wdata = '0;
        bus.f_req = 1'b1; bus.f_addr = 15'd14;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("reset_outputs_zero",
                {24'd0, bus.h_gnt, bus.d_gnt, bus.f_gnt, bus.h_rvalid, bus.d_rvalid,
                 bus.f_rvalid, bus.core_hold, bus.sram_en | bus.sram_we}, 32'd0);
        end
        #1;
        reset = 1'b0;
        bus.h_req = 1'b0;
        #1;
        chk("post_reset_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        chk("post_reset_f_gnt", {31'd0, bus.f_gnt}, 32'd0);
        push(WHO_D, W15);
        tick();
        bus.d_req = 1'b0; bus.f_req = 1'b0;

        // Host session: two writes, a read-back, then release.
        tick();
        bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = 15'd0; bus.h_wdata = 32'h0005_0693;
        #1;
        chk("host_entry_hold", {31'd0, bus.core_hold}, 32'd0);
        chk("host_entry_gnt", {31'd0, bus.h_gnt}, 32'd0);
        tick();
        #1;
        chk("host_hold_rise", {31'd0, bus.core_hold}, 32'd1);
        chk("host_wr0_gnt", {31'd0, bus.h_gnt & bus.sram_we}, 32'd1);
        tick();
        bus.h_addr = 15'd1; bus.h_wdata = 32'h0000_0713;
        #1;
        chk("host_wr1_gnt", {31'd0, bus.h_gnt & bus.sram_we}, 32'd1);
        tick();
        bus.h_we = 1'b0;
        #1;
        chk("host_rd_gnt", {31'd0, bus.h_gnt & bus.sram_en & ~bus.sram_we}, 32'd1);
        push(WHO_H, 32'h0000_0713);
        tick();
        bus.h_req = 1'b0;
        #1;
        chk("host_exit_m", {31'd0, bus.core_hold}, 32'd1);
        tick();
        #1;
        chk("host_exit_m1", {31'd0, bus.core_hold}, 32'd1);
        tick();
        #1;
        chk("host_exit_m2", {31'd0, bus.core_hold}, 32'd0);

        // Data/fetch contention for 10 cycles.
        bus.d_req = 1'b1; bus.d_addr = 15'd15;
        bus.f_req = 1'b1; bus.f_addr = 15'd14;
        for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_FAIRNESS_EN
            exp_f = (i == 4 || i == 9);
`else
            exp_f = 1'b0;
`endif
            #1;
            chk("contention_f_gnt", {31'd0, bus.f_gnt}, {31'd0, exp_f});
            chk("contention_d_gnt", {31'd0, bus.d_gnt}, {31'd0, !exp_f});
            if (exp_f) push(WHO_F, W14);
            else       push(WHO_D, W15);
            tick();
        end
        bus.d_req = 1'b0; bus.f_req = 1'b0;

        // Back-to-back fetch then data read.
        tick();
        bus.f_req = 1'b1; bus.f_addr = 15'd14;
        #1;
        chk("route_f_gnt", {31'd0, bus.f_gnt}, 32'd1);
        push(WHO_F, W14);
        tick();
        bus.f_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 15'd15;
        #1;
        chk("route_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        push(WHO_D, W15);
        tick();
        bus.d_req = 1'b0;

        // Host arrives in the same cycle as a data read grant.
        tick();
        bus.d_req = 1'b1; bus.d_addr = 15'd14;
        bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 15'd0;
        #1;
        chk("preempt_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        push(WHO_D, W14);
        tick();
        #1;
        chk("preempt_host_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        chk("preempt_h_gnt", {31'd0, bus.h_gnt}, 32'd1);
        push(WHO_H, 32'h0005_0693);
        tick();
        bus.h_req = 1'b0;
        #1;
        chk("preempt_m_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        tick();
        #1;
        chk("preempt_m1_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        tick();
        #1;
        chk("preempt_resume_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        push(WHO_D, W14);
        tick();
        bus.d_req = 1'b0;

        // Reset the cycle after a fetch grant: the return is dropped.
        tick();
        bus.f_req = 1'b1; bus.f_addr = 15'd14;
        #1;
        chk("midreset_f_gnt", {31'd0, bus.f_gnt}, 32'd1);
        tick();
        bus.f_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset_f_rvalid", {31'd0, bus.f_rvalid}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("midreset_no_reissue", {31'd0, bus.f_rvalid}, 32'd0);
        chk("midreset_hold", {31'd0, bus.core_hold}, 32'd0);
        bus.d_req = 1'b1; bus.d_addr = 15'd15;
        #1;
        chk("midreset_run_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        push(WHO_D, W15);
        tick();
        bus.d_req = 1'b0;

        repeat (4) tick();
        chk("scoreboard_drain", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
